// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg : state encodings and port-select constants shared
// by the arbiter and the memory-port MUX_2to1 instantiation site.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic SEL_IF  = 1'b0;
  localparam logic SEL_MEM = 1'b1;

  // MEM wins any contest unless IF has hit its starvation limit.
  function automatic logic pick_mem(input logic if_req,
                                    input logic mem_req,
                                    input logic if_starved);
    return mem_req && !(if_req && if_starved);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares the single-ported memory between IF and MEM,
// tracks the fixed read latency and returns completion to the owner. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAT        = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_gnt_o,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              port_sel_o,
  output logic              port_en_o,
  output logic              port_we_o,
  output logic [ADDR_W-1:0] port_addr_o,
  output logic [DATA_W-1:0] port_wdata_o,
  input  logic [DATA_W-1:0] port_rdata_i
);

  localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);
  localparam logic             MULTI_CYC  = (LAT > 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              win_mem;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      sel_q        <= SEL_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    sel_d        = sel_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_gnt_o     = 1'b0;
    mem_gnt_o    = 1'b0;
    port_en_o    = 1'b0;
    port_we_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    mem_done_o   = 1'b0;
    win_mem      = pick_mem(if_req_i, mem_req_i, starve_cnt_q == STARVE_MAX);

    case (state_q)
      // IDLE and DONE share the arbitration step, so DONE can chain straight into ISSUE.
      IDLE, DONE: begin
        if (state_q == DONE) begin
          if_rvalid_o = (sel_q == SEL_IF);
          mem_done_o  = (sel_q == SEL_MEM);
        end
        if (!if_req_i || !win_mem) begin
          starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
        if (if_req_i || mem_req_i) begin
          state_d = ISSUE;
          if (win_mem) begin
            sel_d   = SEL_MEM;
            addr_d  = mem_addr_i;
            we_d    = mem_we_i;
            wdata_d = mem_wdata_i;
          end else begin
            sel_d  = SEL_IF;
            addr_d = if_addr_i;
            we_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if_gnt_o  = (sel_q == SEL_IF);
        mem_gnt_o = (sel_q == SEL_MEM);
        port_en_o = 1'b1;
        port_we_o = we_q;
        lat_cnt_d = LAT_INIT;
        state_d   = MULTI_CYC ? WAIT : DONE;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q <= 4'd1) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign port_sel_o   = sel_q;
  assign port_addr_o  = addr_q;
  assign port_wdata_o = wdata_q;
  assign rdata_o      = port_rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : randomized requesters against a transaction-level
// reference of the arbitration schedule and memory contents.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LAT        = 2;
  localparam int STARVE_LIM = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              if_gnt_o, if_rvalid_o;
  logic              mem_req_i = 1'b0;
  logic              mem_we_i = 1'b0;
  logic [ADDR_W-1:0] mem_addr_i = '0;
  logic [DATA_W-1:0] mem_wdata_i = '0;
  logic              mem_gnt_o, mem_done_o;
  logic [DATA_W-1:0] rdata_o;
  logic              port_sel_o, port_en_o, port_we_o;
  logic [ADDR_W-1:0] port_addr_o;
  logic [DATA_W-1:0] port_wdata_o;
  logic [DATA_W-1:0] port_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_gnt_o(mem_gnt_o), .mem_done_o(mem_done_o),
    .rdata_o(rdata_o), .port_sel_o(port_sel_o),
    .port_en_o(port_en_o), .port_we_o(port_we_o),
    .port_addr_o(port_addr_o), .port_wdata_o(port_wdata_o),
    .port_rdata_i(port_rdata_i)
  );

  // Memory behind the port: writes land on the issue edge, reads follow the held address.
  logic [DATA_W-1:0] mem_arr [256];
  logic [DATA_W-1:0] ref_arr [256];
  always @(posedge clk_i) begin
    if (port_en_o && port_we_o) mem_arr[port_addr_o[7:0]] <= port_wdata_o;
  end
  assign port_rdata_i = mem_arr[port_addr_o[7:0]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference schedule: cycle numbers of the next arbitration, grant and completion.
  int                next_arb = 1;
  int                gnt_cyc  = -1;
  int                done_cyc = -1;
  int                starve   = 0;
  bit                own      = 1'b0;
  logic              exp_we   = 1'b0;
  bit                exp_sel  = 1'b0;
  logic [ADDR_W-1:0] exp_addr  = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  logic [DATA_W-1:0] exp_rdata = '0;
  int                order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input int p_if, input int p_mem, input int p_drop, input bit rst_now);
    int w;
    @(negedge clk_i);
    cyc++;
    chk("if_gnt",    64'(if_gnt_o),     64'(cyc == gnt_cyc && !own));
    chk("mem_gnt",   64'(mem_gnt_o),    64'(cyc == gnt_cyc && own));
    chk("port_en",   64'(port_en_o),    64'(cyc == gnt_cyc));
    chk("port_we",   64'(port_we_o),    64'(cyc == gnt_cyc && exp_we));
    chk("if_rvalid", 64'(if_rvalid_o),  64'(cyc == done_cyc && !own));
    chk("mem_done",  64'(mem_done_o),   64'(cyc == done_cyc && own));
    chk("port_sel",  64'(port_sel_o),   64'(exp_sel));
    chk("port_addr", 64'(port_addr_o),  64'(exp_addr));
    chk("port_wdata",64'(port_wdata_o), 64'(exp_wdata));
    if (cyc == done_cyc) chk("rdata", 64'(rdata_o), 64'(exp_rdata));

    if (if_gnt_o)  begin order.push_back(0); if_req_i  = 1'b0; end
    if (mem_gnt_o) begin order.push_back(1); mem_req_i = 1'b0; end
    if (rst_i) rst_i = 1'b0;

    if (!if_req_i && $urandom_range(99) < p_if) begin
      if_req_i  = 1'b1;
      if_addr_i = $urandom;
    end else if (if_req_i && $urandom_range(99) < p_drop) begin
      if_req_i = 1'b0;
    end
    if (!mem_req_i && $urandom_range(99) < p_mem) begin
      mem_req_i   = 1'b1;
      mem_we_i    = 1'($urandom_range(1));
      mem_addr_i  = $urandom;
      mem_wdata_i = $urandom;
    end else if (mem_req_i && $urandom_range(99) < p_drop) begin
      mem_req_i = 1'b0;
    end

    if (rst_now) begin
      rst_i     = 1'b1;
      gnt_cyc   = -1;
      done_cyc  = -1;
      starve    = 0;
      exp_sel   = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      next_arb  = cyc + 1;
    end else if (cyc == next_arb) begin
      w = -1;
      if (mem_req_i && (!if_req_i || starve < STARVE_LIM)) w = 1;
      else if (if_req_i) w = 0;
      if (w == 0 || !if_req_i) starve = 0;
      else if (starve < STARVE_LIM) starve++;
      if (w < 0) begin
        next_arb = cyc + 1;
      end else begin
        own      = (w == 1);
        exp_sel  = (w == 1);
        gnt_cyc  = cyc + 1;
        done_cyc = cyc + 1 + LAT;
        next_arb = done_cyc;
        if (w == 1) begin
          exp_addr  = mem_addr_i;
          exp_we    = mem_we_i;
          exp_wdata = mem_wdata_i;
          if (mem_we_i) ref_arr[mem_addr_i[7:0]] = mem_wdata_i;
        end else begin
          exp_addr = if_addr_i;
          exp_we   = 1'b0;
        end
        exp_rdata = ref_arr[exp_addr[7:0]];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      ref_arr[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    repeat (3) @(negedge clk_i);

    for (int i = 0; i < 400; i++) step(30, 30, 10, 1'b0);

    // Reset while an access is in its latency window.
    for (int k = 0; k < 3; k++) begin
      int guard = 0;
      while (cyc != gnt_cyc && guard < 50) begin
        step(60, 60, 0, 1'b0);
        guard++;
      end
      chk("reach_issue", 64'(guard < 50), 64'(1));
      step(60, 60, 0, 1'b1);
      for (int i = 0; i < 20; i++) step(40, 40, 0, 1'b0);
    end

    // Both requesters held continuously from a clean reset.
    step(100, 100, 0, 1'b1);
    order.delete();
    for (int i = 0; i < 40; i++) step(100, 100, 0, 1'b0);
    chk("order_len", 64'(order.size() >= 10), 64'(1));
    if (order.size() >= 10) begin
      for (int i = 0; i < 10; i++) chk("grant_order", 64'(order[i]), 64'((i % 5 == 4) ? 0 : 1));
    end

    for (int i = 0; i < 300; i++) step(20, 40, 50, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
